// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: state encoding, count width,
// default timing constants and the saturating counter step.
package pwm_capture_pkg;

    localparam int CNT_W          = 8;
    localparam int TIMEOUT_DEF    = 255;
    localparam int MIN_PERIOD_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEAS  = 2'd1,
        ST_STUCK = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer for an asynchronous level plus one delay flop used
// to detect rising edges of the synchronized level.
module pwm_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain followed by the edge-detect delay stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM stream, flags
// glitch periods and declares the input stuck after a long edge-free gap.
// The FSM captures into internal registers; a final output stage presents
// all results together one cycle later.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck,
    output logic             err
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);

    logic             level;
    logic             rise;
    logic [CNT_W-1:0] cnt_p;
    logic [CNT_W-1:0] cnt_h;
    state_t           state;
    logic [CNT_W-1:0] cap_period;
    logic [CNT_W-1:0] cap_duty;
    logic             cap_stuck;
    logic             cap_upd;
    logic             cap_err;

    pwm_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pwm_in),
        .level (level),
        .rise  (rise)
    );

    // Period and high-time counters; both restart on every rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p <= {CNT_W{1'b0}};
            cnt_h <= {CNT_W{1'b0}};
        end else if (rise) begin
            cnt_p <= {{(CNT_W-1){1'b0}}, 1'b1};
            cnt_h <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_p <= sat_inc(cnt_p);
            if (level) begin
                cnt_h <= sat_inc(cnt_h);
            end else begin
                cnt_h <= cnt_h;
            end
        end
    end

    // Measurement FSM: rise takes priority over timeout; disable discards
    // the running measurement but keeps the captured results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cap_period <= {CNT_W{1'b0}};
            cap_duty   <= {CNT_W{1'b0}};
            cap_stuck  <= 1'b0;
            cap_upd    <= 1'b0;
            cap_err    <= 1'b0;
        end else begin
            cap_upd <= 1'b0;
            cap_err <= 1'b0;
            if (!en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state     <= ST_MEAS;
                            cap_stuck <= 1'b0;
                        end else if (cnt_p >= TIMEOUT_C) begin
                            state      <= ST_STUCK;
                            cap_stuck  <= 1'b1;
                            cap_period <= {CNT_W{1'b0}};
                            cap_duty   <= level ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
                            cap_upd    <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_MEAS: begin
                        if (rise) begin
                            if (cnt_p >= MIN_C) begin
                                cap_period <= cnt_p;
                                cap_duty   <= cnt_h;
                                cap_upd    <= 1'b1;
                            end else begin
                                cap_err <= 1'b1;
                            end
                        end else if (cnt_p >= TIMEOUT_C) begin
                            state      <= ST_STUCK;
                            cap_stuck  <= 1'b1;
                            cap_period <= {CNT_W{1'b0}};
                            cap_duty   <= level ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
                            cap_upd    <= 1'b1;
                        end else begin
                            state <= ST_MEAS;
                        end
                    end
                    ST_STUCK: begin
                        if (rise) begin
                            state     <= ST_MEAS;
                            cap_stuck <= 1'b0;
                        end else begin
                            state <= ST_STUCK;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Output stage: results and their strobes leave the block together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty   <= {CNT_W{1'b0}};
            period <= {CNT_W{1'b0}};
            valid  <= 1'b0;
            stuck  <= 1'b0;
            err    <= 1'b0;
        end else begin
            duty   <= cap_duty;
            period <= cap_period;
            valid  <= cap_upd;
            stuck  <= cap_stuck;
            err    <= cap_err;
        end
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles without a rising edge before the input is declared stuck (range 8..255).
REQ-002 SHALL have parameter MIN_PERIOD, default 4: shortest legal period in cycles; shorter periods are glitches.
REQ-003 SHALL have ports: clk input 1 system clock; rst input 1 reset, asynchronous, active-high.
REQ-004 SHALL have port en input 1: capture enable; 0 forces IDLE.
REQ-005 SHALL have port pwm_in input 1: asynchronous PWM stream, e.g. the LED breathing output, period 128 cycles.
REQ-006 SHALL have port duty output 8: high-time of the last measured period, in cycles.
REQ-007 SHALL have port period output 8: length of the last measured period, in cycles.
REQ-008 SHALL have port valid output 1: one-cycle pulse when duty/period/stuck update.
REQ-009 SHALL have port stuck output 1: 1 while the input has had no rising edge for TIMEOUT cycles.
REQ-010 SHALL have port err output 1: one-cycle pulse on a glitch period.

Function
REQ-011 pwm_in SHALL pass a 2-FF synchronizer (s2) plus one delay flop (s3); rise = s2 & ~s3.
REQ-012 States SHALL be IDLE, MEAS and STUCK; reset and en=0 force IDLE.
REQ-013 cnt_p (8-bit, saturating at 255) SHALL load 1 on every rise cycle and otherwise increment each cycle in every state.
REQ-014 cnt_h (8-bit, saturating) SHALL load 1 on rise, increment while s2=1, and hold after s2 falls.
REQ-015 IDLE: rise -> MEAS with no capture; cnt_p reaching TIMEOUT -> STUCK.
REQ-016 MEAS, rise with cnt_p >= MIN_PERIOD: period<=cnt_p, duty<=cnt_h, and valid SHALL pulse the following cycle; stay in MEAS.
REQ-017 MEAS, rise with cnt_p < MIN_PERIOD: err SHALL pulse the following cycle, outputs hold, no valid, counters reload, stay in MEAS.
REQ-018 MEAS or IDLE, cnt_p == TIMEOUT with no rise -> STUCK: stuck<=1, period<=0, duty<=8'hFF if s2=1 else 8'h00, valid pulse once.
REQ-019 STUCK: outputs hold; on rise, stuck<=0 -> MEAS, no valid until the next full period completes.
REQ-020 Rise and timeout in the same cycle: rise SHALL win.
REQ-021 Latency: pwm_in rising edge sampled at clk edge k -> valid high after edge k+3.
REQ-022 valid and err SHALL never be asserted in the same cycle.
REQ-023 en falling mid-period: the partial measurement SHALL be discarded and outputs hold their last values.

Reset
REQ-024 rst SHALL asynchronously force: state IDLE, synchronizer flops 0, cnt_p 0, cnt_h 0, duty 0, period 0, valid 0, stuck 0, err 0.
REQ-025 Release of rst SHALL need no input-edge alignment; the first valid comes only after two rises.

Structure
REQ-026 A shared package SHALL hold the state encoding, the 8-bit count width, and the default TIMEOUT and MIN_PERIOD constants.
REQ-027 SHALL instantiate exactly one sub-module, pwm_sync (2-FF synchronizer and rise detect), reusable by other input captures.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from pwm_in to any output.

Verification
REQ-029 Period 128, high 32, ten periods -> from the second rise onward, one valid per period with duty=32, period=128, err=0.
REQ-030 Period 128, high 1 (minimum brightness) -> duty=1, period=128; high 127 -> duty=127.
REQ-031 pwm_in held at 1 after reset -> valid after TIMEOUT cycles with stuck=1, duty=8'hFF, period=0; held at 0 -> duty=8'h00.
REQ-032 Stuck high, then resume period 64, high 16 -> stuck clears on the first rise, next valid gives duty=16, period=64.
REQ-033 2-cycle glitch period inserted between normal periods -> err pulses once, no valid, and the next normal period measures correctly.
REQ-034 rst asserted mid-period, asynchronously to clk -> all outputs 0 immediately; after release, two rises are needed before valid.
